// File: rtl/regfile_wb_ctrl_if.sv
// Write-back request channel from the datapath into regfile_wb_ctrl.
// A transfer completes on a rising edge where valid and ready are both high.
interface regfile_wb_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (output valid, addr, data, input ready);
    modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back queue with read forwarding from pending writes.
// Optional REGFILE_WB_ZERO_REG_EN makes register 0 hard-wired to zero.
module regfile_wb_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_ctrl_if.slave       wb,
    input  logic                   drain_hold,
    input  logic                   rd_req,
    input  logic [ADDR_W-1:0]      rd_addr_a,
    input  logic [ADDR_W-1:0]      rd_addr_b,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data_a,
    output logic [DATA_W-1:0]      rd_data_b,
    output logic                   rf_write,
    output logic [ADDR_W-1:0]      rf_wr_addr,
    output logic [DATA_W-1:0]      rf_wr_data,
    output logic [ADDR_W-1:0]      rf_rd_addr_a,
    output logic [ADDR_W-1:0]      rf_rd_addr_b,
    input  logic [DATA_W-1:0]      rf_rd_data_a,
    input  logic [DATA_W-1:0]      rf_rd_data_b,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] q_addr_q [DEPTH];
    logic [ADDR_W-1:0] q_addr_d [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];
    logic [DATA_W-1:0] q_data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;

    logic              push;
    logic              push_en;
    logic              pop;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [PTR_W-1:0]  idx;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign count        = count_q;
    assign wb.ready     = !full;
    assign push         = wb.valid && !full;
    assign pop          = !empty && !drain_hold;
    assign rf_write     = pop;
    assign rf_wr_addr   = q_addr_q[rd_ptr_q];
    assign rf_wr_data   = q_data_q[rd_ptr_q];
    assign rf_rd_addr_a = rd_addr_a;
    assign rf_rd_addr_b = rd_addr_b;
    assign rd_valid     = rd_valid_q;
    assign rd_data_a    = rd_data_a_q;
    assign rd_data_b    = rd_data_b_q;

`ifdef REGFILE_WB_ZERO_REG_EN
    // Writes to r0 complete the handshake but are dropped.
    assign push_en = push && (wb.addr != '0);
`else
    assign push_en = push;
`endif

    always_comb begin
        q_addr_d = q_addr_q;
        q_data_d = q_data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            q_addr_d[wr_ptr_q] = wb.addr;
            q_data_d[wr_ptr_q] = wb.data;
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_en) - CNT_W'(pop);
    end

    // Oldest-to-youngest scan so the youngest match wins.
    always_comb begin
        fwd_a = rf_rd_data_a;
        fwd_b = rf_rd_data_b;
        idx   = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (q_addr_q[idx] == rd_addr_a) fwd_a = q_data_q[idx];
                if (q_addr_q[idx] == rd_addr_b) fwd_b = q_data_q[idx];
            end
        end
        if (push && (wb.addr == rd_addr_a)) fwd_a = wb.data;
        if (push && (wb.addr == rd_addr_b)) fwd_b = wb.data;
`ifdef REGFILE_WB_ZERO_REG_EN
        if (rd_addr_a == '0) fwd_a = '0;
        if (rd_addr_b == '0) fwd_b = '0;
`endif
    end

    always_comb begin
        rd_valid_d  = rd_req;
        rd_data_a_d = rd_req ? fwd_a : rd_data_a_q;
        rd_data_b_d = rd_req ? fwd_b : rd_data_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr_q[i] <= '0;
                q_data_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            q_addr_q    <= q_addr_d;
            q_data_q    <= q_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a behavioural 16x16 register file.
// The file model resets to zero once and is never cleared by rst_n.
module tb_regfile_wb_ctrl;
    logic        clk;
    logic        rst_n;
    logic        drain_hold;
    logic        rd_req;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic        rd_valid;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rf_write;
    logic [3:0]  rf_wr_addr, rf_rd_addr_a, rf_rd_addr_b;
    logic [15:0] rf_wr_data, rf_rd_data_a, rf_rd_data_b;
    logic [2:0]  count;
    logic        empty, full;
    logic [15:0] rf_mem [16];

    int errors = 0;
    int checks = 0;

    regfile_wb_ctrl_if #(.ADDR_W(4), .DATA_W(16)) wb_if ();

    regfile_wb_ctrl #(.DEPTH(4), .DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .wb(wb_if),
        .drain_hold(drain_hold), .rd_req(rd_req),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rf_write(rf_write), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (rf_write) rf_mem[rf_wr_addr] <= rf_wr_data;
    assign rf_rd_data_a = rf_mem[rf_rd_addr_a];
    assign rf_rd_data_b = rf_mem[rf_rd_addr_b];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_if.valid = 1'b0;
        rd_req      = 1'b0;
        drain_hold  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags got e=%b f=%b want e=1 f=0", empty, full); end
        checks++; if (rd_valid !== 1'b0 || rd_data_a !== 16'h0) begin errors++; $display("FAIL rst_rd got v=%b a=%h want v=0 a=0000", rd_valid, rd_data_a); end
        step();
        rst_n = 1'b1;
        step();
        rd_req = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd7;
        #1;
        checks++; if (rf_write !== 1'b0 || wb_if.ready !== 1'b1) begin errors++; $display("FAIL idle_ctl got wr=%b rdy=%b want wr=0 rdy=1", rf_write, wb_if.ready); end
        step();
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin errors++; $display("FAIL idle_read got v=%b a=%h b=%h want v=1 a=0000 b=0000", rd_valid, rd_data_a, rd_data_b); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got %b want 0", rd_valid); end
    endtask

    task automatic test_single();
        wb_if.valid = 1'b1; wb_if.addr = 4'd5; wb_if.data = 16'hBEEF;
        step();
        wb_if.valid = 1'b0;
        #1;
        checks++; if (rf_write !== 1'b1 || rf_wr_addr !== 4'd5 || rf_wr_data !== 16'hBEEF) begin errors++; $display("FAIL single_commit got wr=%b a=%0d d=%h want wr=1 a=5 d=beef", rf_write, rf_wr_addr, rf_wr_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        step();
        checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_drained got c=%0d e=%b want c=0 e=1", count, empty); end
        rd_req = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd3;
        step();
        rd_req = 1'b0;
        checks++; if (rd_data_a !== 16'hBEEF || rd_data_b !== 16'h0) begin errors++; $display("FAIL single_read got a=%h b=%h want a=beef b=0000", rd_data_a, rd_data_b); end
    endtask

    task automatic test_fwd_same_cycle();
        wb_if.valid = 1'b1; wb_if.addr = 4'd2; wb_if.data = 16'h1234;
        rd_req = 1'b1; rd_addr_a = 4'd2; rd_addr_b = 4'd2;
        step();
        idle();
        checks++; if (rd_valid !== 1'b1 || rd_data_a !== 16'h1234 || rd_data_b !== 16'h1234) begin errors++; $display("FAIL fwd_push got v=%b a=%h b=%h want v=1 a=1234 b=1234", rd_valid, rd_data_a, rd_data_b); end
        step();
        step();
    endtask

    task automatic test_hold_full();
        drain_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wb_if.valid = 1'b1;
            wb_if.addr  = 4'(k + 1);
            wb_if.data  = 16'(17 * (k + 1));
            step();
        end
        wb_if.addr = 4'd6; wb_if.data = 16'h0066;
        #1;
        checks++; if (full !== 1'b1 || wb_if.ready !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL full_flags got f=%b rdy=%b c=%0d want f=1 rdy=0 c=4", full, wb_if.ready, count); end
        checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL hold_write got %b want 0", rf_write); end
        step();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_no_push got %0d want 4", count); end
        wb_if.valid = 1'b0;
        drain_hold  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (rf_write !== 1'b1 || rf_wr_addr !== 4'(k + 1) || rf_wr_data !== 16'(17 * (k + 1))) begin errors++; $display("FAIL drain_%0d got wr=%b a=%0d d=%h want wr=1 a=%0d d=%h", k, rf_write, rf_wr_addr, rf_wr_data, k + 1, 16'(17 * (k + 1))); end
            step();
        end
        #1;
        checks++; if (empty !== 1'b1 || rf_write !== 1'b0) begin errors++; $display("FAIL drain_end got e=%b wr=%b want e=1 wr=0", empty, rf_write); end
        rd_req = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd4;
        step();
        rd_req = 1'b0;
        checks++; if (rd_data_a !== 16'h0033 || rd_data_b !== 16'h0044) begin errors++; $display("FAIL drain_file got a=%h b=%h want a=0033 b=0044", rd_data_a, rd_data_b); end
    endtask

    task automatic test_youngest_wins();
        drain_hold = 1'b1;
        wb_if.valid = 1'b1; wb_if.addr = 4'd9; wb_if.data = 16'hAAAA;
        step();
        wb_if.data = 16'hBBBB;
        step();
        wb_if.valid = 1'b0;
        rd_req = 1'b1; rd_addr_a = 4'd9; rd_addr_b = 4'd1;
        step();
        rd_req = 1'b0;
        checks++; if (rd_data_a !== 16'hBBBB || rd_data_b !== 16'h0011) begin errors++; $display("FAIL youngest_fwd got a=%h b=%h want a=bbbb b=0011", rd_data_a, rd_data_b); end
        drain_hold = 1'b0;
        step();
        step();
        checks++; if (empty !== 1'b1 || rf_mem[9] !== 16'hBBBB) begin errors++; $display("FAIL youngest_file got e=%b r9=%h want e=1 r9=bbbb", empty, rf_mem[9]); end
    endtask

    task automatic test_back_to_back();
        drain_hold = 1'b1;
        wb_if.valid = 1'b1; wb_if.addr = 4'd7; wb_if.data = 16'h7777;
        step();
        drain_hold = 1'b0;
        wb_if.addr = 4'd8; wb_if.data = 16'h8888;
        rd_req = 1'b1; rd_addr_a = 4'd7; rd_addr_b = 4'd8;
        step();
        idle();
        checks++; if (count !== 3'd1 || rf_wr_addr !== 4'd8) begin errors++; $display("FAIL push_pop got c=%0d head=%0d want c=1 head=8", count, rf_wr_addr); end
        checks++; if (rd_data_a !== 16'h7777 || rd_data_b !== 16'h8888) begin errors++; $display("FAIL push_pop_fwd got a=%h b=%h want a=7777 b=8888", rd_data_a, rd_data_b); end
        step();
        checks++; if (rf_mem[7] !== 16'h7777 || rf_mem[8] !== 16'h8888) begin errors++; $display("FAIL push_pop_file got r7=%h r8=%h want 7777 8888", rf_mem[7], rf_mem[8]); end
    endtask

    task automatic test_reset_mid_drain();
        drain_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wb_if.valid = 1'b1;
            wb_if.addr  = 4'(10 + k);
            wb_if.data  = 16'h0C00 + 16'(k);
            step();
        end
        wb_if.valid = 1'b0;
        rd_req = 1'b1; rd_addr_a = 4'd10; rd_addr_b = 4'd12;
        #2;
        rst_n = 1'b0;
        drain_hold = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || empty !== 1'b1 || rf_write !== 1'b0) begin errors++; $display("FAIL mid_rst got c=%0d e=%b wr=%b want c=0 e=1 wr=0", count, empty, rf_write); end
        step();
        rd_req = 1'b0;
        checks++; if (rd_valid !== 1'b0 || rd_data_a !== 16'h0) begin errors++; $display("FAIL mid_rst_rd got v=%b a=%h want v=0 a=0000", rd_valid, rd_data_a); end
        rst_n = 1'b1;
        step();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        checks++; if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin errors++; $display("FAIL mid_rst_file got a=%h b=%h want 0000 0000", rd_data_a, rd_data_b); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 16'h0;
        rst_n = 1'b0;
        wb_if.valid = 1'b0; wb_if.addr = 4'd0; wb_if.data = 16'h0;
        drain_hold = 1'b0; rd_req = 1'b0;
        rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        test_reset();
        test_single();
        test_fwd_same_cycle();
        test_hold_full();
        test_youngest_wins();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Initiator-side controller for the 16x16 register file: owns the write port and both read ports.
- Accepts write-back requests from the datapath through a valid/ready handshake and buffers them in a small in-order queue. Drains one entry per cycle into the register file.
- Serves two-operand read requests with a registered result. Results are forwarded from queued, not-yet-committed writes, so reads always return the newest architectural value.

Parameters:
- DEPTH, 4, write-back queue entries (power of two, >=2)
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (16 registers)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  write-back request valid
- wb_ready  out  1  queue can accept a request
- wb_addr  in  ADDR_W  destination register
- wb_data  in  DATA_W  write-back data
- drain_hold  in  1  1 = do not commit the queue head this cycle
- rd_req  in  1  operand read request
- rd_addr_a  in  ADDR_W  operand A register
- rd_addr_b  in  ADDR_W  operand B register
- rd_valid  out  1  operand data valid (registered)
- rd_data_a  out  DATA_W  operand A value
- rd_data_b  out  DATA_W  operand B value
- rf_write  out  1  register file write enable
- rf_wr_addr  out  ADDR_W  register file write address
- rf_wr_data  out  DATA_W  register file write data
- rf_rd_addr_a  out  ADDR_W  register file read address A (= rd_addr_a, combinational)
- rf_rd_addr_b  out  ADDR_W  register file read address B (= rd_addr_b, combinational)
- rf_rd_data_a  in  DATA_W  register file read data A (combinational from file)
- rf_rd_data_b  in  DATA_W  register file read data B
- count  out  $clog2(DEPTH)+1  queue occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: queue emptied (count=0, empty=1, full=0), read/write pointers 0, rd_valid=0, rd_data_a/b=0. Assertion mid-operation discards all pending entries; there is no partial commit.
- Push:
  - A push occurs when wb_valid && wb_ready at a posedge.
  - wb_ready = !full. This is conservative: no push into a full queue even if a pop happens the same cycle.
- Commit (pop):
  - rf_write = !empty && !drain_hold, combinational.
  - rf_wr_addr/rf_wr_data = head entry; they hold the head value whenever the queue is non-empty.
  - The pop occurs at the same posedge the register file captures the write.
- Simultaneous push and pop: count is unchanged, and both pointers advance modulo DEPTH.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count.
- Read:
  - rd_req at edge N gives rd_valid=1 during cycle N+1 with rd_data_a/b. Latency is 1.
  - With no rd_req, rd_valid=0 the next cycle and rd_data_a/b hold their previous value.
- Forwarding priority, per operand, highest first:
  1. Same-cycle accepted push with a matching address.
  2. Youngest queued entry with a matching address (including the head being committed this cycle).
  3. rf_rd_data.
- Result of forwarding: a read issued in the same cycle as a write-back to that register returns the new data.
- Duplicate addresses in the queue: all are committed in order. The final register value equals the youngest write.
- drain_hold=1 with the queue full: wb_ready=0. Requesters must hold wb_valid/wb_addr/wb_data stable until accepted.

Optional Feature:
- Macro: REGFILE_WB_ZERO_REG_EN.
- Defined:
  - Register 0 is hard-zero. Reads of address 0 return 0 regardless of the queue or file.
  - Write-backs to address 0 are accepted (handshake completes) but not enqueued; count is unchanged.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then idle: rd_req with A=3, B=7 on an all-zero file -> next cycle rd_valid=1, rd_data_a=0, rd_data_b=0; empty=1, rf_write=0.
- Single write-back of addr=5, data=16'hBEEF, drain_hold=0 -> rf_write=1, rf_wr_addr=5 the same cycle; count returns to 0; a later read of A=5 returns 16'hBEEF.
- Same-cycle forwarding: push addr=2, data=16'h1234 with rd_req A=2, B=2 at the same edge -> next cycle rd_data_a=rd_data_b=16'h1234.
- Hold/full: drain_hold=1, push 4 entries (addr 1..4, data 16'h0011..16'h0044) -> full=1, wb_ready=0, count=4. Release drain_hold -> four consecutive rf_write cycles with addr 1,2,3,4, then empty=1.
- Youngest-wins: drain_hold=1, push addr=9 data=16'hAAAA then addr=9 data=16'hBBBB; read A=9 -> 16'hBBBB. After draining, the file holds 16'hBBBB.
- Reset mid-drain: 3 entries queued under drain_hold, assert rst_n=0 -> count=0, rf_write=0 immediately; the file is unchanged by the discarded entries.
